// File: rtl/pid_servo_mc_pkg.sv
// pid_servo_mc_pkg: shared types and constants for the multi-channel PID servo.
//   state_t   sweep FSM states
//   sat_t     result of the duty saturation step (duty word, clamped flag, clamp direction)
//   sat_duty  converts a MAC accumulator into a clamped duty word
package pid_servo_mc_pkg;

    localparam int OUT_W    = 17;
    localparam int ACC_W    = 48;
    localparam int FRAC     = 8;
    localparam int DUTY_MIN = 50000;
    localparam int DUTY_CTR = 75000;
    localparam int DUTY_MAX = 100000;

    typedef enum logic [2:0] {
        S_IDLE, S_ERR, S_MP, S_MI, S_MD, S_OUT, S_DONE
    } state_t;

    typedef struct packed {
        logic [OUT_W-1:0] duty;
        logic             sat;   // clamped to either limit
        logic             hi;    // clamped to the ceiling (only meaningful with sat)
    } sat_t;

    // u = centre + (acc >>> FRAC), clamped to [DUTY_MIN, DUTY_MAX].
    function automatic sat_t sat_duty(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] u;
        sat_t r;
        u      = ACC_W'(DUTY_CTR) + (acc >>> FRAC);
        r.duty = OUT_W'(u);
        r.sat  = 1'b0;
        r.hi   = 1'b0;
        if (u > ACC_W'(DUTY_MAX)) begin
            r.duty = OUT_W'(DUTY_MAX);
            r.sat  = 1'b1;
            r.hi   = 1'b1;
        end else if (u < ACC_W'(DUTY_MIN)) begin
            r.duty = OUT_W'(DUTY_MIN);
            r.sat  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pid_servo_mc_if.sv
// pid_servo_mc_if: control/data bundle between the sensor/setpoint registers,
// the servo controller and the PWM generators.
//   master: drives sample_tick/en/clr, gains, setpoint, fb; receives results
//   slave : the controller side
interface pid_servo_mc_if #(
    parameter int N_CH   = 4,
    parameter int IN_W   = 16,
    parameter int OUT_W  = 17,
    parameter int GAIN_W = 16
);
    logic                     sample_tick;
    logic                     en;
    logic                     clr;
    logic signed [GAIN_W-1:0] kp, ki, kd;
    logic [N_CH*IN_W-1:0]     setpoint;
    logic [N_CH*IN_W-1:0]     fb;
    logic [N_CH*OUT_W-1:0]    duty_out;
    logic [N_CH-1:0]          sat;
    logic                     busy;
    logic                     done;
    logic                     overrun;

    modport master (
        output sample_tick, en, clr, kp, ki, kd, setpoint, fb,
        input  duty_out, sat, busy, done, overrun
    );
    modport slave (
        input  sample_tick, en, clr, kp, ki, kd, setpoint, fb,
        output duty_out, sat, busy, done, overrun
    );
endinterface

// File: rtl/pid_servo_mc_mac.sv
// pid_servo_mc_mac: signed A_W x B_W multiply with registered accumulate.
//   clr_acc  zero the accumulator (wins over en)
//   en       acc <= acc + a*b
//   a, b     signed operands
//   acc      accumulator, ACC_W signed
module pid_servo_mc_mac #(
    parameter int A_W   = 16,
    parameter int B_W   = 32,
    parameter int ACC_W = 48
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_acc,
    input  logic                    en,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] acc
);
    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] acc_q;

    assign prod = P_W'(a) * P_W'(b);
    assign acc  = acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       acc_q <= '0;
        else if (clr_acc) acc_q <= '0;
        else if (en)      acc_q <= acc_q + ACC_W'(prod);
    end
endmodule

// File: rtl/pid_servo_mc.sv
// pid_servo_mc: time-multiplexed N_CH-channel PID servo. A sample_tick runs one
// sweep (5 cycles per channel) through a single shared MAC and publishes all
// duty words together on done.
//   clk, rst_n  clock, async active-low reset
//   bus         pid_servo_mc_if.slave (tick/en/clr, gains, setpoint/fb in;
//               duty_out/sat/busy/done/overrun out)
module pid_servo_mc
    import pid_servo_mc_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int IN_W   = 16,
    parameter int GAIN_W = 16,
    parameter int INT_W  = 32,
    parameter int I_LIM  = 2**20
) (
    input  logic           clk,
    input  logic           rst_n,
    pid_servo_mc_if.slave  bus
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int E_W  = IN_W + 1;
    localparam logic signed [INT_W:0] LIM = (INT_W+1)'(I_LIM);

    state_t                   state_q;
    logic [CH_W-1:0]          ch_q;
    logic signed [GAIN_W-1:0] kp_q, ki_q, kd_q;
    logic signed [E_W-1:0]    e_q;
    logic signed [E_W:0]      d_q;
    logic signed [INT_W-1:0]  in_q;
    logic signed [INT_W-1:0]  integ_q  [N_CH];
    logic signed [E_W-1:0]    last_e_q [N_CH];
    logic [OUT_W-1:0]         shadow_q [N_CH];
    logic [N_CH-1:0]          sat_sh_q;
    logic [N_CH-1:0][OUT_W-1:0] duty_q;
    logic [N_CH-1:0]          sat_q;
    logic                     done_q, overrun_q;

    logic [IN_W-1:0]          sp_ch, fb_ch;
    logic signed [E_W-1:0]    e_d;
    logic signed [E_W:0]      d_d;
    logic signed [INT_W:0]    isum;
    logic signed [INT_W-1:0]  in_d;
    logic signed [GAIN_W-1:0] mac_a;
    logic signed [INT_W-1:0]  mac_b;
    logic                     mac_en, mac_clr, tick_ok, hold;
    logic signed [ACC_W-1:0]  acc;
    sat_t                     res;

    assign tick_ok = bus.sample_tick & bus.en & ~bus.clr;

    always_comb begin
        sp_ch = bus.setpoint[int'(ch_q)*IN_W +: IN_W];
        fb_ch = bus.fb[int'(ch_q)*IN_W +: IN_W];
        e_d   = E_W'(sp_ch) - E_W'(fb_ch);
        d_d   = (E_W+1)'(e_d) - (E_W+1)'(last_e_q[ch_q]);
        isum  = (INT_W+1)'(integ_q[ch_q]) + (INT_W+1)'(e_d);
        if (isum > LIM)       in_d = INT_W'(LIM);
        else if (isum < -LIM) in_d = INT_W'(-LIM);
        else                  in_d = INT_W'(isum);

        mac_a = kp_q;
        mac_b = INT_W'(e_q);
        case (state_q)
            S_MI:    begin mac_a = ki_q; mac_b = in_q;         end
            S_MD:    begin mac_a = kd_q; mac_b = INT_W'(d_q);  end
            default: ;
        endcase
        mac_en  = (state_q == S_MP) || (state_q == S_MI) || (state_q == S_MD);
        mac_clr = (state_q == S_ERR) || bus.clr;

        res  = sat_duty(acc);
        // Freeze the integrator only when it would push further into the clamp.
        hold = (res.hi && !e_q[E_W-1] && (e_q != '0)) ||
               (res.sat && !res.hi && e_q[E_W-1]);
    end

    pid_servo_mc_mac #(.A_W(GAIN_W), .B_W(INT_W), .ACC_W(ACC_W)) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_acc (mac_clr),
        .en      (mac_en),
        .a       (mac_a),
        .b       (mac_b),
        .acc     (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            kp_q      <= '0;
            ki_q      <= '0;
            kd_q      <= '0;
            e_q       <= '0;
            d_q       <= '0;
            in_q      <= '0;
            sat_sh_q  <= '0;
            sat_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                integ_q[i]  <= '0;
                last_e_q[i] <= '0;
                shadow_q[i] <= OUT_W'(DUTY_CTR);
                duty_q[i]   <= OUT_W'(DUTY_CTR);
            end
        end else if (bus.clr) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            sat_sh_q  <= '0;
            sat_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                integ_q[i]  <= '0;
                last_e_q[i] <= '0;
                shadow_q[i] <= OUT_W'(DUTY_CTR);
                duty_q[i]   <= OUT_W'(DUTY_CTR);
            end
        end else begin
            done_q    <= 1'b0;
            overrun_q <= tick_ok && (state_q != S_IDLE);
            case (state_q)
                S_IDLE: if (tick_ok) begin
                    kp_q    <= bus.kp;
                    ki_q    <= bus.ki;
                    kd_q    <= bus.kd;
                    ch_q    <= '0;
                    state_q <= S_ERR;
                end
                S_ERR: begin
                    e_q     <= e_d;
                    d_q     <= d_d;
                    in_q    <= in_d;
                    state_q <= S_MP;
                end
                S_MP: state_q <= S_MI;
                S_MI: state_q <= S_MD;
                S_MD: state_q <= S_OUT;
                S_OUT: begin
                    shadow_q[ch_q] <= res.duty;
                    sat_sh_q[ch_q] <= res.sat;
                    last_e_q[ch_q] <= e_q;
                    if (!hold) integ_q[ch_q] <= in_q;
                    if (ch_q == CH_W'(N_CH-1)) begin
                        // Publish here so duty_out/sat change in the same cycle done is high;
                        // the last channel's fresh result bypasses its shadow slot.
                        for (int i = 0; i < N_CH; i++) begin
                            duty_q[i] <= (i == N_CH-1) ? res.duty : shadow_q[i];
                            sat_q[i]  <= (i == N_CH-1) ? res.sat  : sat_sh_q[i];
                        end
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        ch_q    <= ch_q + 1'b1;
                        state_q <= S_ERR;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.duty_out = duty_q;
    assign bus.sat      = sat_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_pid_servo_mc.sv
// tb_pid_servo_mc: directed, table-driven bench for pid_servo_mc, plus short
// hand-written sequences for integrator clamp, en gating, overrun, clr and reset.
module tb_pid_servo_mc;
    localparam int N_CH = 4, IN_W = 16, OUT_W = 17, GAIN_W = 16;
    localparam int CTR = 75000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pid_servo_mc_if #(.N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W), .GAIN_W(GAIN_W)) bus();

    pid_servo_mc #(.N_CH(N_CH), .IN_W(IN_W), .GAIN_W(GAIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit clr;
        int chn;
        int kp, ki, kd;
        int sp, fb;
        int exp_duty;
        bit exp_sat;
    } vec_t;

    vec_t vt[14];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int duty(input int c);
        return int'(bus.duty_out[c*OUT_W +: OUT_W]);
    endfunction

    task automatic set_ch(input int c, input int sp, input int fbv);
        bus.setpoint = '0;
        bus.fb       = '0;
        bus.setpoint[c*IN_W +: IN_W] = IN_W'(sp);
        bus.fb[c*IN_W +: IN_W]       = IN_W'(fbv);
    endtask

    task automatic set_gains(input int kp, input int ki, input int kd);
        bus.kp = GAIN_W'(kp);
        bus.ki = GAIN_W'(ki);
        bus.kd = GAIN_W'(kd);
    endtask

    task automatic do_clr();
        @(negedge clk); bus.clr = 1'b1;
        @(negedge clk); bus.clr = 1'b0;
    endtask

    // Tick, then wait (bounded) for done; lat = cycles from tick to done, 0 on timeout.
    task automatic sweep(output int lat);
        lat = 0;
        @(negedge clk); bus.sample_tick = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.sample_tick = 1'b0;
            if (bus.done) begin lat = c; break; end
        end
    endtask

    initial begin
        int lat, ndone;
        longint ex, ig;

        //        clr ch   kp     ki     kd   sp    fb    duty    sat
        vt[0]  = '{1, 0,   256,     0,   0, 1000,    0,  76000, 0};
        vt[1]  = '{1, 0, 25600,     0,   0, 1000,    0, 100000, 1};
        vt[2]  = '{1, 0, 25600,     0,   0,    0, 1000,  50000, 1};
        vt[3]  = '{1, 0,     0,   256,   0,   10,    0,  75010, 0};
        vt[4]  = '{0, 0,     0,   256,   0,   10,    0,  75020, 0};
        vt[5]  = '{0, 0,     0,   256,   0,   10,    0,  75030, 0};
        vt[6]  = '{1, 0,     0,     0, 256,    0,    0,  75000, 0};
        vt[7]  = '{0, 0,     0,     0, 256,   50,    0,  75050, 0};
        vt[8]  = '{0, 0,     0,     0, 256,   50,    0,  75000, 0};
        vt[9]  = '{1, 0,     0, 25600,   0, 1000,    0, 100000, 1};
        vt[10] = '{0, 0,     0, 25600,   0, 1000,    0, 100000, 1};
        vt[11] = '{0, 0,     0,   256,   0,   10,    0,  75010, 0};  // integ held at 0 by anti-windup
        vt[12] = '{1, 0,   128,     0,   0,    0,    3,  74998, 0};  // -1.5 floors to -2
        vt[13] = '{1, 2,   256,     0,   0,    0,  500,  74500, 0};

        bus.sample_tick = 1'b0;
        bus.en          = 1'b1;
        bus.clr         = 1'b0;
        set_gains(0, 0, 0);
        set_ch(0, 0, 0);

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < N_CH; i++) begin
            chk($sformatf("reset duty%0d", i), duty(i), CTR);
        end
        chk("reset sat", bus.sat, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset overrun", bus.overrun, 0);
        rst_n = 1'b1;

        // Table vectors
        for (int k = 0; k < 14; k++) begin
            if (vt[k].clr) do_clr();
            set_gains(vt[k].kp, vt[k].ki, vt[k].kd);
            set_ch(vt[k].chn, vt[k].sp, vt[k].fb);
            sweep(lat);
            chk($sformatf("v%0d latency", k), lat, 21);
            for (int i = 0; i < N_CH; i++) begin
                chk($sformatf("v%0d duty%0d", k, i), duty(i),
                    (i == vt[k].chn) ? vt[k].exp_duty : CTR);
                chk($sformatf("v%0d sat%0d", k, i), bus.sat[i],
                    (i == vt[k].chn) ? vt[k].exp_sat : 1'b0);
            end
        end

        // Integrator clamp at 2^20: ki = 1/256, e = 65535 each sweep
        do_clr();
        set_gains(0, 1, 0);
        set_ch(0, 65535, 0);
        for (int k = 1; k <= 18; k++) begin
            sweep(lat);
            ig = 65535 * k;
            if (ig > 1048576) ig = 1048576;
            ex = CTR + (ig >> 8);
            chk($sformatf("clamp k%0d duty0", k), duty(0), ex);
        end

        // en = 0: tick ignored
        do_clr();
        set_gains(256, 0, 0);
        set_ch(0, 1000, 0);
        bus.en = 1'b0;
        @(negedge clk); bus.sample_tick = 1'b1;
        @(negedge clk); bus.sample_tick = 1'b0;
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.busy || bus.done) ndone++;
        end
        chk("en0 no activity", ndone, 0);
        chk("en0 duty0", duty(0), CTR);
        bus.en = 1'b1;

        // Overrun: second tick at busy cycle 5 is dropped
        lat = 0; ndone = 0;
        @(negedge clk); bus.sample_tick = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            bus.sample_tick = (c == 5);
            if (c == 1)  chk("ovr busy c1", bus.busy, 1);
            if (c == 6)  chk("ovr pulse", bus.overrun, 1);
            if (c == 7)  chk("ovr pulse end", bus.overrun, 0);
            if (c == 22) chk("ovr busy after done", bus.busy, 0);
            if (bus.done) begin ndone++; if (lat == 0) lat = c; end
        end
        chk("ovr latency", lat, 21);
        chk("ovr done count", ndone, 1);
        chk("ovr duty0", duty(0), 76000);

        // clr mid-sweep: back to IDLE, centre duty, no done
        ndone = 0;
        @(negedge clk); bus.sample_tick = 1'b1;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            bus.sample_tick = 1'b0;
            bus.clr = (c == 10);
            if (c == 11) begin
                chk("clr busy", bus.busy, 0);
                chk("clr duty0", duty(0), CTR);
                chk("clr sat", bus.sat, 0);
            end
            if (bus.done) ndone++;
        end
        chk("clr no done", ndone, 0);

        // rst_n mid-sweep after a completed sweep moved duty0 off centre
        sweep(lat);
        chk("pre-rst duty0", duty(0), 76000);
        @(negedge clk); bus.sample_tick = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus.sample_tick = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst mid duty0", duty(0), CTR);
        chk("rst mid busy", bus.busy, 0);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("rst mid no done", ndone, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
